// File: rtl/online_div_pkg.sv
// Shared widths, thresholds, FSM states and digit encodings for the online divider
// residue/digit-selection stage.
package online_div_pkg;

  localparam int unsigned RES_LO_W = 4;
  localparam int unsigned RES_HI_W = 6;
  localparam int unsigned EST_W    = RES_HI_W + 1;
  localparam int unsigned RES_W    = RES_HI_W + RES_LO_W;

  // Estimate thresholds and bound, in units of 1/4
  localparam logic signed [EST_W-1:0] SEL_POS   = 7'sd2;
  localparam logic signed [EST_W-1:0] SEL_NEG   = -7'sd3;
  localparam logic signed [EST_W-1:0] RES_BOUND = 7'sd12;

  // Correction applied to the upper vector opposite in sign to the digit (one unit)
  localparam logic [RES_HI_W-1:0] CORR_STEP = 6'd4;

  // Digit encoding as {q_plus, q_minus}
  localparam logic [1:0] DIGIT_ZERO = 2'b00;
  localparam logic [1:0] DIGIT_POS  = 2'b10;
  localparam logic [1:0] DIGIT_NEG  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/digit_select_shift.sv
// Combinational digit selection: estimate from the upper borrow-save pair, pick q,
// correct the upper vectors and shift the full residue left by one.
module digit_select_shift
  import online_div_pkg::*;
(
  input  logic [RES_HI_W-1:0] upper_plus,
  input  logic [RES_HI_W-1:0] upper_minus,
  input  logic [RES_LO_W-1:0] lower_plus,
  input  logic [RES_LO_W-1:0] lower_minus,
  output logic                q_plus,
  output logic                q_minus,
  output logic [RES_HI_W-1:0] next_upper_plus,
  output logic [RES_HI_W-1:0] next_upper_minus,
  output logic [RES_LO_W-1:0] next_plus,
  output logic [RES_LO_W-1:0] next_minus,
  output logic                bound_err
);

  logic signed [EST_W-1:0] est;
  logic [1:0]              digit;
  logic [RES_HI_W-1:0]     corr_plus;
  logic [RES_HI_W-1:0]     corr_minus;
  logic [RES_W-1:0]        full_plus;
  logic [RES_W-1:0]        full_minus;
  logic [RES_W-1:0]        shl_plus;
  logic [RES_W-1:0]        shl_minus;

  always_comb begin
    est = $signed({1'b0, upper_plus}) - $signed({1'b0, upper_minus});

    digit = DIGIT_ZERO;
    if (est >= SEL_POS) begin
      digit = DIGIT_POS;
    end else if (est <= SEL_NEG) begin
      digit = DIGIT_NEG;
    end

    // Subtracting q is done by adding to the opposite vector; wraps mod 64
    corr_plus  = upper_plus;
    corr_minus = upper_minus;
    if (digit == DIGIT_POS) begin
      corr_minus = upper_minus + CORR_STEP;
    end else if (digit == DIGIT_NEG) begin
      corr_plus = upper_plus + CORR_STEP;
    end

    full_plus  = {corr_plus, lower_plus};
    full_minus = {corr_minus, lower_minus};
    shl_plus   = {full_plus[RES_W-2:0], 1'b0};
    shl_minus  = {full_minus[RES_W-2:0], 1'b0};

    next_upper_plus  = shl_plus[RES_W-1:RES_LO_W];
    next_plus        = shl_plus[RES_LO_W-1:0];
    next_upper_minus = shl_minus[RES_W-1:RES_LO_W];
    next_minus       = shl_minus[RES_LO_W-1:0];

    q_plus    = digit[1];
    q_minus   = digit[0];
    bound_err = (est >= RES_BOUND) || (est <= -RES_BOUND);
  end

endmodule

// File: rtl/online_digit_selector.sv
// Digit-selector wrapper: start/run/done sequencing over DIGITS digits, digit counter,
// sticky overflow flag and registered digit/residue outputs.
module online_digit_selector
  import online_div_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [RES_LO_W-1:0] residue_plus,
  input  logic [RES_LO_W-1:0] residue_minus,
  input  logic [RES_HI_W-1:0] residue_upper_plus,
  input  logic [RES_HI_W-1:0] residue_upper_minus,
  output logic                in_ready,
  output logic                q_plus,
  output logic                q_minus,
  output logic                out_valid,
  output logic [RES_LO_W-1:0] next_plus,
  output logic [RES_LO_W-1:0] next_minus,
  output logic [RES_HI_W-1:0] next_upper_plus,
  output logic [RES_HI_W-1:0] next_upper_minus,
  output logic [CNT_W-1:0]    digit_count,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                accept;

  logic                sel_q_plus, sel_q_minus, sel_bound_err;
  logic [RES_HI_W-1:0] sel_up, sel_um;
  logic [RES_LO_W-1:0] sel_p, sel_m;

  logic                q_plus_q, q_minus_q, out_valid_q;
  logic [RES_HI_W-1:0] next_up_q, next_um_q;
  logic [RES_LO_W-1:0] next_p_q, next_m_q;

  digit_select_shift u_sel (
    .upper_plus       (residue_upper_plus),
    .upper_minus      (residue_upper_minus),
    .lower_plus       (residue_plus),
    .lower_minus      (residue_minus),
    .q_plus           (sel_q_plus),
    .q_minus          (sel_q_minus),
    .next_upper_plus  (sel_up),
    .next_upper_minus (sel_um),
    .next_plus        (sel_p),
    .next_minus       (sel_m),
    .bound_err        (sel_bound_err)
  );

  assign accept = in_valid && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (sel_bound_err) begin
            ovf_d = 1'b1;
          end
          if (count_d == CNT_W'(DIGITS)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Back-to-back divisions skip IDLE
        if (start) begin
          state_d = RUN;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      q_plus_q    <= 1'b0;
      q_minus_q   <= 1'b0;
      next_up_q   <= '0;
      next_um_q   <= '0;
      next_p_q    <= '0;
      next_m_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= accept;
      if (accept) begin
        q_plus_q  <= sel_q_plus;
        q_minus_q <= sel_q_minus;
        next_up_q <= sel_up;
        next_um_q <= sel_um;
        next_p_q  <= sel_p;
        next_m_q  <= sel_m;
      end
    end
  end

  assign in_ready         = (state_q == RUN);
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign q_plus           = q_plus_q;
  assign q_minus          = q_minus_q;
  assign out_valid        = out_valid_q;
  assign next_upper_plus  = next_up_q;
  assign next_upper_minus = next_um_q;
  assign next_plus        = next_p_q;
  assign next_minus       = next_m_q;
  assign digit_count      = count_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_online_digit_selector.sv
// Scoreboard bench for online_digit_selector: directed residue vectors with hand-computed
// digits and shifted residues, FSM sequencing, overflow and mid-division reset.
module tb_online_digit_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] residue_plus, residue_minus;
  logic [5:0] residue_upper_plus, residue_upper_minus;
  logic       in_ready, q_plus, q_minus, out_valid;
  logic [3:0] next_plus, next_minus;
  logic [5:0] next_upper_plus, next_upper_minus;
  logic [7:0] digit_count;
  logic       busy, done, overflow;

  online_digit_selector #(.DIGITS(8), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .in_valid            (in_valid),
    .residue_plus        (residue_plus),
    .residue_minus       (residue_minus),
    .residue_upper_plus  (residue_upper_plus),
    .residue_upper_minus (residue_upper_minus),
    .in_ready            (in_ready),
    .q_plus              (q_plus),
    .q_minus             (q_minus),
    .out_valid           (out_valid),
    .next_plus           (next_plus),
    .next_minus          (next_minus),
    .next_upper_plus     (next_upper_plus),
    .next_upper_minus    (next_upper_minus),
    .digit_count         (digit_count),
    .busy                (busy),
    .done                (done),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] up, um;
    logic [3:0] p, m;
    logic [1:0] q;
    logic [5:0] nup, num;
    logic [3:0] np, nm;
  } vec_t;

  typedef struct packed {
    logic [1:0] q;
    logic [5:0] nup, num;
    logic [3:0] np, nm;
    logic       dn;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [5:0] up, um, input logic [3:0] p, m,
                         input logic [1:0] q, input logic [5:0] nup, num,
                         input logic [3:0] np, nm);
    tbl[i].up = up;  tbl[i].um = um;  tbl[i].p = p;  tbl[i].m = m;
    tbl[i].q = q;    tbl[i].nup = nup; tbl[i].num = num;
    tbl[i].np = np;  tbl[i].nm = nm;
  endtask

  // q encoded {q_plus, q_minus}
  initial begin
    set_vec(0,  3,  0,  8, 0, 2'b10,  7,  8,  0, 0);
    set_vec(1,  0,  3,  0, 0, 2'b01,  8,  6,  0, 0);
    set_vec(2,  1,  0,  0, 0, 2'b00,  2,  0,  0, 0);
    set_vec(3, 12,  0,  0, 0, 2'b10, 24,  8,  0, 0);
    set_vec(4,  5,  5,  5, 3, 2'b00, 10, 10, 10, 6);
    set_vec(5,  0,  2, 15, 0, 2'b00,  1,  4, 14, 0);
    set_vec(6, 63,  0,  0, 0, 2'b10, 62,  8,  0, 0);
    set_vec(7,  0, 63,  0, 0, 2'b01,  8, 62,  0, 0);
    set_vec(8, 60, 61,  0, 9, 2'b00, 56, 59,  0, 2);
    set_vec(9, 62, 60,  0, 0, 2'b10, 60,  0,  0, 0);
    set_vec(10, 60, 63, 0, 0, 2'b01,  0, 62,  0, 0);
  end

  task automatic send(input int i, input logic last, input logic st);
    exp_t x;
    @(negedge clk);
    residue_upper_plus  = tbl[i].up;
    residue_upper_minus = tbl[i].um;
    residue_plus        = tbl[i].p;
    residue_minus       = tbl[i].m;
    in_valid            = 1'b1;
    start               = st;
    x.q = tbl[i].q; x.nup = tbl[i].nup; x.num = tbl[i].num;
    x.np = tbl[i].np; x.nm = tbl[i].nm; x.dn = last;
    sb.push_back(x);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_qp"}, q_plus, 0);
    chk({tag, "_qm"}, q_minus, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_nup"}, next_upper_plus, 0);
    chk({tag, "_num"}, next_upper_minus, 0);
    chk({tag, "_np"}, next_plus, 0);
    chk({tag, "_nm"}, next_minus, 0);
    chk({tag, "_cnt"}, digit_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  // Monitor: pops an expectation on every out_valid
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("q", {q_plus, q_minus}, e.q);
          chk("next_upper_plus", next_upper_plus, e.nup);
          chk("next_upper_minus", next_upper_minus, e.num);
          chk("next_plus", next_plus, e.np);
          chk("next_minus", next_minus, e.nm);
          chk("done_with_digit", done, e.dn);
        end
      end else begin
        chk("done_without_digit", done, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int seq_a[8] = '{0, 1, 2, 4, 5, 8, 9, 10};
  int seq_b[8] = '{3, 0, 1, 2, 6, 7, 4, 5};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    residue_plus = '0; residue_minus = '0;
    residue_upper_plus = '0; residue_upper_minus = '0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Division A: continuous stream with one gap and a start while running
    do_start();
    chk("run_busy", busy, 1);
    chk("run_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("gap_out_valid", out_valid, 0);
        chk("gap_hold_nup", next_upper_plus, tbl[seq_a[3]].nup);
        chk("gap_count", digit_count, 4);
      end
      send(seq_a[i], i == 7, i == 2);
    end
    @(negedge clk) in_valid = 1'b0;
    chk("a_done", done, 1);
    chk("a_done_ready", in_ready, 0);
    chk("a_count", digit_count, 8);
    chk("a_ovf", overflow, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    // in_valid in IDLE must be ignored
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_count_hold", digit_count, 8);

    // Division B: overflow on first digit stays set; restart straight from DONE
    do_start();
    for (int i = 0; i < 8; i++) begin
      send(seq_b[i], i == 7, 1'b0);
      if (i == 1) chk("b_ovf_set", overflow, 1);
    end
    @(negedge clk) in_valid = 1'b0;
    chk("b_done", done, 1);
    chk("b_ovf_sticky", overflow, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_ovf_clr", overflow, 0);
    chk("restart_cnt_clr", digit_count, 0);

    // Division C: reset after three digits
    send(3, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_count", digit_count, 3);
    chk("pre_rst_ovf", overflow, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_cnt", digit_count, 0);

    // Clean division after reset
    do_start();
    for (int i = 0; i < 8; i++) send(seq_a[i], i == 7, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    chk("c_done", done, 1);
    chk("c_count", digit_count, 8);
    chk("c_ovf", overflow, 0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/online_digit_selector.md
Name: online_digit_selector

Overview:
- Consumer end of the stage-two residue interface of the online divider.
- Each cycle it accepts one borrow-save residue pair: a 6-bit upper part and a 4-bit lower part, each split into plus and minus vectors.
- It selects the quotient digit q in {-1, 0, +1} from the upper-part estimate, applies the correction, shifts the residue left by one, and returns it for the next iteration.
- Runs a start/iterate/done sequence over a fixed number of digits.

Parameters:
- DIGITS, 8, number of quotient digits produced per division (1..255).
- CNT_W, 8, width of the digit counter.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a division; honoured only in IDLE or DONE.
- in_valid  input  1  residue inputs valid this cycle.
- residue_plus  input  4  lower residue, positive vector.
- residue_minus  input  4  lower residue, negative vector.
- residue_upper_plus  input  6  upper residue, positive vector.
- residue_upper_minus  input  6  upper residue, negative vector.
- in_ready  output  1  high in RUN; an input is accepted when in_valid && in_ready.
- q_plus  output  1  registered digit, positive bit.
- q_minus  output  1  registered digit, negative bit (q = q_plus - q_minus; never both 1).
- out_valid  output  1  q and next_* are valid this cycle.
- next_plus  output  4  shifted, corrected lower residue, positive.
- next_minus  output  4  shifted, corrected lower residue, negative.
- next_upper_plus  output  6  shifted, corrected upper residue, positive.
- next_upper_minus  output  6  shifted, corrected upper residue, negative.
- digit_count  output  CNT_W  digits accepted in the current division.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the last digit is output.
- overflow  output  1  sticky residue-bound violation flag.

Behaviour:
- Reset values (asynchronous, active-high):
  - state = IDLE.
  - All outputs 0, including q_plus/q_minus, next_*, digit_count, overflow, done, out_valid and busy.
- States:
  - IDLE: start -> RUN; clear digit_count and overflow.
  - RUN: in_ready = 1. Each accepted input increments digit_count. When the accept makes digit_count == DIGITS -> DONE.
  - DONE: done = 1 for exactly this one cycle, then -> IDLE. A start in DONE -> RUN directly, with the same clearing as from IDLE.
  - start while in RUN is ignored.
- Estimate:
  - v = signed(residue_upper_plus) - signed(residue_upper_minus), computed 7-bit signed from zero-extended operands.
  - v is in units of 1/4.
- Selection:
  - v >= 2 -> q = +1.
  - v <= -3 -> q = -1.
  - otherwise q = 0.
- Correction on the upper vectors, mod 64:
  - q = +1: add 4 to upper_minus.
  - q = -1: add 4 to upper_plus.
  - q = 0: unchanged.
- Shift:
  - Form P = {upper_plus', residue_plus} and M = {upper_minus', residue_minus}, 10 bits each.
  - Shift each left by 1, dropping the MSB and inserting 0 at the LSB.
  - Split each result back into 6-bit upper and 4-bit lower parts to drive next_*.
- Latency:
  - q, next_* and out_valid are registered: 1 cycle after accept.
  - out_valid = 1 only in the cycle after an accepted input.
  - Outputs hold their values when no accept occurs.
- Overflow:
  - Set when an accepted v >= 12 or v <= -12.
  - Stays set until the next start or rst.
  - The digit is still produced normally.
- in_valid outside RUN is ignored: no count change, out_valid = 0.
- done and the out_valid of the final digit coincide in the cycle after the last accept.
- rst asserted mid-division aborts it immediately. No done pulse; counter and outputs return to 0.

Decomposition:
- Shared package online_div_pkg holds:
  - Width constants RES_LO_W = 4 and RES_HI_W = 6.
  - Selection thresholds SEL_POS = 2 and SEL_NEG = -3.
  - Bound constant RES_BOUND = 12.
  - State enum IDLE / RUN / DONE.
  - Digit encoding constants.
- One combinational sub-module, digit_select_shift: estimate, selection, correction and shift. The wrapper holds the FSM, counter and output registers.

Test Plan:
- Reset then start; accept upper_plus = 3, upper_minus = 0, plus = 4'b1000, minus = 0 -> next cycle q = +1 (q_plus = 1), next_upper_plus = 7, next_upper_minus = 8, next_plus = 0, next_minus = 0, out_valid = 1.
- Accept upper_plus = 0, upper_minus = 3, lower parts 0 -> q = -1, next_upper_plus = 8, next_upper_minus = 6.
- Accept upper_plus = 1, upper_minus = 0 (v = 1) -> q = 0, next_upper_plus = 2, next_upper_minus = 0.
- DIGITS = 8 with in_valid high continuously after start -> 8 out_valid pulses, done high in the same cycle as the 8th out_valid, then state IDLE with in_ready = 0. start during RUN has no effect.
- Accept v = 12 (upper_plus = 12) -> overflow = 1 and stays 1 through the rest of the division; the next start clears it.
- Assert rst after 3 digits -> all outputs 0 immediately, digit_count = 0, no done; a new start runs a clean 8-digit division.
